// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: in-place radix-2 DIT FFT controller wrapped around an external combinational butterfly.
// Ports: i_clk/i_rst (sync active-high); i_data/i_valid/o_ready load one frame of N samples;
// o_bf_A/o_bf_B/o_twiddle feed the butterfly and i_bf_A/i_bf_B return its results;
// o_data/o_valid/i_ready stream bins out in natural order; o_busy flags the compute phase.
// Build option FFT_BITREV_EN: load in natural order (bit-reversed write address); otherwise the source supplies bit-reversed order.
module fft_stage_sequencer #(
    parameter int WORD_SZ  = 32,
    parameter int WORD_MID = 16,
    parameter int LOG2N    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [WORD_SZ-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WORD_SZ-1:0] o_bf_A,
    output logic [WORD_SZ-1:0] o_bf_B,
    output logic [WORD_SZ-1:0] o_twiddle,
    input  logic [WORD_SZ-1:0] i_bf_A,
    input  logic [WORD_SZ-1:0] i_bf_B,
    output logic [WORD_SZ-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy
);
    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    localparam int N  = 1 << LOG2N;
    localparam int SW = $clog2(LOG2N);
    // Twiddles of a 16-point transform; smaller N picks every (16/N)-th entry.
    localparam logic [7:0][WORD_MID-1:0] TW_RE = {
        WORD_MID'(-59), WORD_MID'(-45), WORD_MID'(-24), WORD_MID'(0),
        WORD_MID'(24),  WORD_MID'(45),  WORD_MID'(59),  WORD_MID'(64)};
    localparam logic [7:0][WORD_MID-1:0] TW_IM = {
        WORD_MID'(-24), WORD_MID'(-45), WORD_MID'(-59), WORD_MID'(-64),
        WORD_MID'(-59), WORD_MID'(-45), WORD_MID'(-24), WORD_MID'(0)};
    state_t             state_q;
    logic [LOG2N-1:0]   cnt_q, wr_addr, jw, half, pos, top, bot;
    logic [SW-1:0]      s_q;
    logic [LOG2N-2:0]   j_q;
    logic [2:0]         tw_k;
    logic [WORD_SZ-1:0] mem_q [N];
`ifdef FFT_BITREV_EN
    assign wr_addr = {<<{cnt_q}};
`else
    assign wr_addr = cnt_q;
`endif
    always_comb begin
        jw   = {1'b0, j_q};
        half = LOG2N'(1) << s_q;
        pos  = jw & (half - 1'b1);
        // Clear bit s of j by shifting it up one place: yields the top index of group j>>s.
        top  = (((jw >> s_q) << s_q) << 1) + pos;
        bot  = top + half;
        tw_k = 3'((int'(pos) << (LOG2N - 1 - int'(s_q))) << (4 - LOG2N));
    end
    assign o_ready   = state_q == LOAD;
    assign o_busy    = state_q == COMPUTE;
    assign o_valid   = state_q == UNLOAD;
    assign o_data    = o_valid ? mem_q[cnt_q] : '0;
    assign o_bf_A    = o_busy ? mem_q[top] : '0;
    assign o_bf_B    = o_busy ? mem_q[bot] : '0;
    assign o_twiddle = o_busy ? {TW_RE[tw_k], TW_IM[tw_k]} : '0;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            s_q     <= '0;
            j_q     <= '0;
        end else begin
            case (state_q)
                LOAD: if (i_valid) begin
                    mem_q[wr_addr] <= i_data;
                    cnt_q          <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= COMPUTE;
                end
                COMPUTE: begin
                    mem_q[top] <= i_bf_A;
                    mem_q[bot] <= i_bf_B;
                    j_q        <= j_q + 1'b1;
                    if (&j_q) begin
                        s_q <= s_q + 1'b1;
                        if (s_q == SW'(LOG2N - 1)) begin
                            s_q     <= '0;
                            state_q <= UNLOAD;
                        end
                    end
                end
                UNLOAD: if (i_ready) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed frames through the sequencer with a behavioural butterfly in the loop.
module tb_fft_stage_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_valid = 1'b0, i_ready = 1'b0;
    logic        o_ready, o_valid, o_busy;
    logic [31:0] o_bf_A, o_bf_B, o_twiddle, bf_a, bf_b, o_data;
    logic [31:0] frame [8];
    logic [31:0] expv [8];
    logic [31:0] got [8];
    int          cmps = 0, errs = 0, n = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_bf_A(o_bf_A), .o_bf_B(o_bf_B), .o_twiddle(o_twiddle), .i_bf_A(bf_a), .i_bf_B(bf_b),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    function automatic logic [31:0] bfly(input logic [31:0] a, b, w, input bit sub);
        int ar, ai, br, bi, wr, wi, pr, pi;
        ar = int'($signed(a[31:16])); ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16])); bi = int'($signed(b[15:0]));
        wr = int'($signed(w[31:16])); wi = int'($signed(w[15:0]));
        pr = (wr * br - wi * bi) >>> 6;
        pi = (wr * bi + wi * br) >>> 6;
        return sub ? {16'(ar - pr), 16'(ai - pi)} : {16'(ar + pr), 16'(ai + pi)};
    endfunction

    assign bf_a = bfly(o_bf_A, o_bf_B, o_twiddle, 1'b0);
    assign bf_b = bfly(o_bf_A, o_bf_B, o_twiddle, 1'b1);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_frame;
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = frame[i];
            step;
        end
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            step;
            cyc++;
        end
    endtask

    task automatic unload(input bit bp);
        int k = 0, cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] prev = '0;
        while (k < 8 && cyc < 100) begin
            i_ready = bp ? (cyc % 3 == 0) : 1'b1;
            chk("unload_ready_low", o_ready, 0);
            if (stalled) begin
                chk("stall_data_hold", o_data, prev);
                chk("stall_valid_hold", o_valid, 1);
            end
            if (o_valid && i_ready) begin
                got[k] = o_data;
                k++;
            end
            stalled = o_valid && !i_ready;
            prev    = o_data;
            step;
            cyc++;
        end
        i_ready = 1'b0;
        chk("unload_count", k, 8);
        chk("post_unload_ready", o_ready, 1);
        chk("post_unload_valid", o_valid, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("bin%0d", i), got[i], expv[i]);
    endtask

    initial begin
        step;
        step;
        rst = 1'b0;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_bf_A", o_bf_A, 0);
        chk("rst_bf_B", o_bf_B, 0);
        chk("rst_twiddle", o_twiddle, 0);

        // Impulse at sample 0: every bin equals {64,0}.
        for (int i = 0; i < 8; i++) begin
            frame[i] = (i == 0) ? 32'h0040_0000 : 32'h0;
            expv[i]  = 32'h0040_0000;
        end
        load_frame;
        chk("impulse_busy", o_busy, 1);
        chk("impulse_ready_low", o_ready, 0);
        wait_valid(n);
        chk("impulse_latency", n, 12);
        unload(1'b0);

        // DC frame with junk offered during compute and 1,0,0 backpressure on the output.
        for (int i = 0; i < 8; i++) begin
            frame[i] = 32'h0040_0000;
            expv[i]  = (i == 0) ? 32'h0200_0000 : 32'h0;
        end
        load_frame;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        wait_valid(n);
        i_valid = 1'b0;
        i_data  = '0;
        chk("dc_latency", n, 12);
        unload(1'b1);

        // Reset during compute cycle 5, then a clean impulse frame.
        for (int i = 0; i < 8; i++) begin
            frame[i] = (i == 0) ? 32'h0040_0000 : 32'h0;
            expv[i]  = 32'h0040_0000;
        end
        load_frame;
        repeat (4) step;
        chk("midrst_busy_before", o_busy, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_valid", o_valid, 0);
        load_frame;
        wait_valid(n);
        chk("midrst_latency", n, 12);
        unload(1'b0);

        // x[1]={64,0}: stream slot 1 when the block reverses addresses, slot 4 when the source must.
        for (int i = 0; i < 8; i++) frame[i] = '0;
`ifdef FFT_BITREV_EN
        frame[1] = 32'h0040_0000;
`else
        frame[4] = 32'h0040_0000;
`endif
        expv[0] = 32'h0040_0000; expv[1] = 32'h002D_FFD3;
        expv[2] = 32'h0000_FFC0; expv[3] = 32'hFFD3_FFD3;
        expv[4] = 32'hFFC0_0000; expv[5] = 32'hFFD3_002D;
        expv[6] = 32'h0000_0040; expv[7] = 32'h002D_002D;
        load_frame;
        repeat (9) step;
        chk("trace_twiddle", o_twiddle, 32'h002D_FFD3);
        chk("trace_bf_A_mem1", o_bf_A, 32'h0);
        chk("trace_bf_B_mem5", o_bf_B, 32'h0040_0000);
        wait_valid(n);
        chk("bitrev_remaining_latency", n, 3);
        unload(1'b0);
        chk("idle_twiddle", o_twiddle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Radix-2 decimation-in-time FFT controller that sits directly around `butterfly_sum`. It buffers one frame of N complex samples and feeds operand pairs plus twiddle factors to the combinational butterfly, one butterfly per clock. It writes the butterfly results back in place and, after log2(N) stages, streams the transformed frame out under a valid/ready handshake.

## Interface
- `WORD_SZ`, 32, complex word width: `{real[31:16], imag[15:0]}`.
- `WORD_MID`, 16, component width; two's complement, 6 fractional bits (1.0 = 64).
- `LOG2N`, 3, log2 of frame length N; legal range 2..4.

Ports:
- `i_clk` input 1: the single clock; all logic is rising-edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_data` input WORD_SZ: input sample.
- `i_valid` input 1: `i_data` is valid.
- `o_ready` output 1: block accepts samples.
- `o_bf_A` output WORD_SZ: butterfly top operand, to `butterfly_sum.i_A`.
- `o_bf_B` output WORD_SZ: butterfly bottom operand, to `i_B`.
- `o_twiddle` output WORD_SZ: twiddle factor, to `i_twiddleA`.
- `i_bf_A` input WORD_SZ: butterfly result A, from `o_A`.
- `i_bf_B` input WORD_SZ: butterfly result B, from `o_B`.
- `o_data` output WORD_SZ: output bin.
- `o_valid` output 1: `o_data` is valid.
- `i_ready` input 1: downstream accepts `o_data`.
- `o_busy` output 1: high in COMPUTE.

## Operation
- **Storage.** N-entry register array `mem`; combinational read, one write port pair per cycle. Reset does not clear `mem`.
- **States.** LOAD → COMPUTE → UNLOAD → LOAD.
- **LOAD.**
  - `o_ready=1`.
  - Each `i_valid & o_ready` edge writes `i_data` to `mem[wr_addr(cnt)]` and increments `cnt`.
  - The edge accepting sample N-1 clears `cnt` and enters COMPUTE.
- **COMPUTE.** Counters are stage `s` (0..LOG2N-1) and butterfly `j` (0..N/2-1).
  - `half = 1<<s`, `pos = j & (half-1)`.
  - `top = ((j>>s)<<(s+1)) + pos`, `bot = top + half`.
  - `o_bf_A = mem[top]`, `o_bf_B = mem[bot]`.
  - `o_twiddle = W[pos << (LOG2N-1-s)]`.
  - Each edge writes `i_bf_A → mem[top]` and `i_bf_B → mem[bot]`, then advances `j`.
  - When `j` wraps, `s` increments. After the last butterfly of stage LOG2N-1, the block enters UNLOAD.
- **Twiddle ROM.**
  - `W[k].real = round(64·cos(2πk/N))`, `W[k].imag = -round(64·sin(2πk/N))`, k < N/2.
  - N=8 entries: {64,0}, {45,-45}, {0,-64}, {-45,-45}.
- **UNLOAD.**
  - `o_valid=1`, `o_data = mem[cnt]` in natural order.
  - `cnt` advances only on `o_valid & i_ready`.
  - The handshake on bin N-1 enters LOAD.
- **Arithmetic.** No scaling in this block. Component overflow wraps modulo 2^16, as produced by `butterfly_sum`.
- **Idle operand outputs.** Outside COMPUTE, `o_bf_A`, `o_bf_B` and `o_twiddle` drive 0.
- **Reset values.**
  - State LOAD, `cnt=s=j=0`.
  - `o_ready=1`, `o_valid=0`, `o_busy=0`.
  - `o_data=0`, `o_bf_A=o_bf_B=o_twiddle=0`.

## Timing
- **Load.** Minimum N cycles; gaps in `i_valid` are allowed. `i_valid` while `o_ready=0` is ignored and the sample dropped.
- **Compute latency.** Fixed at (N/2)·LOG2N cycles; 12 for N=8.
  - Let edge E0 accept the last sample.
  - `o_busy` is high from E0 through E12.
  - `o_valid` rises after E12.
- **Unload.** Minimum N cycles. With `i_ready=0`, `o_data` and `o_valid` hold stable.
- **Next frame.**
  - `o_ready` rises the cycle after the final output handshake.
  - No overlap: input is never accepted during COMPUTE or UNLOAD.
- **Reset mid-frame.** Asserting `i_rst` in any state returns the block to LOAD with counters zeroed on that edge. The partial frame is discarded; stale `mem` contents are overwritten by the next load.

## Configuration
- **`FFT_BITREV_EN` defined:** `wr_addr(cnt)` is the LOG2N-bit reversal of `cnt`, so input is taken in natural order.
- **`FFT_BITREV_EN` not defined:** `wr_addr(cnt) = cnt`. The source must supply samples already in bit-reversed order.
- Output order is natural in both builds.

## Test plan
- **Impulse.** N=8, bitrev on. Samples {64,0} then seven zeros → all 8 outputs {64,0}.
- **DC.** Eight samples {64,0} → bin0 = {512,0}; bins 1..7 = {0,0}. `o_valid` rises exactly 12 cycles after the last accept.
- **Backpressure.** Same DC frame with `i_ready` toggling 1,0,0,1… → no bin lost or duplicated, and `o_data` is stable while stalled. `o_ready` stays 0 until one cycle after the bin-7 handshake.
- **Reset mid-compute.** Assert `i_rst` at compute cycle 5 → next cycle `o_busy=0`, `o_ready=1`, `o_valid=0`. A following impulse frame then yields all {64,0}.
- **Bit-reversal build.** Bitrev off; feed x[4]={64,0} first, i.e. the bit-reversed position of sample 1, zeros elsewhere. Bin k must equal `W8^k` scaled: bin0={64,0}, bin2={0,-64}, bin4={-64,0}.
- **Operand trace.** During stage 2, butterfly j=1 → `top=1`, `bot=5`, `o_twiddle={45,-45}`.
